cpu_fw_scoreboard: RTL and testbench

Parametrised next-generation forwarding unit for the CPU pipeline. For each of NUM_SRC decode-stage source operands, it picks the youngest valid bypass among NUM_FW_STAGES producer stages. A per-register latency scoreboard tracks in-flight multi-cycle producers (loads, multiplies) and stalls decode until their result is forwardable. It sits beside the ID stage, fed by the issue bus and the downstream stage destination/writeback fields.

---
 rtl/cpu_fw_pkg.sv | 12 +
 rtl/cpu_fw_select.sv | 23 ++
 rtl/cpu_fw_scoreboard.sv | 71 +++++++
 tb/tb_cpu_fw_scoreboard.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cpu_fw_pkg.sv
// cpu_fw_pkg: shared constants, types and select encoding for the forwarding unit.
package cpu_fw_pkg;
  localparam int SEL_REGFILE = 0;
  localparam int FW_STAGES = 2;
  localparam int LAT_BITS = 2;
  localparam int SEL_BITS = $clog2(FW_STAGES + 1);
  typedef logic [SEL_BITS-1:0] bypass_sel_t;
  typedef logic [LAT_BITS-1:0] lat_t;
  function automatic int stage_sel(input int k);
    return k + 1;
  endfunction
endpackage

// File: rtl/cpu_fw_select.sv
// cpu_fw_select: per-source priority matcher picking the youngest writing stage.
module cpu_fw_select
  import cpu_fw_pkg::*;
#(
  parameter int NUM_FW_STAGES = FW_STAGES,
  parameter int REG_W = 5,
  parameter int SEL_W = $clog2(NUM_FW_STAGES + 1),
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic [REG_W-1:0]               src_reg_i,
  input  logic                           src_used_i,
  input  logic [NUM_FW_STAGES*REG_W-1:0] stage_rd_i,
  input  logic [NUM_FW_STAGES-1:0]       stage_we_i,
  output logic [SEL_W-1:0]               sel_o
);
  always_comb begin
    sel_o = SEL_W'(SEL_REGFILE);
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int k = NUM_FW_STAGES - 1; k >= 0; k--)
      if (stage_we_i[k] && stage_rd_i[k*REG_W +: REG_W] == src_reg_i) sel_o = SEL_W'(stage_sel(k));
    if (!src_used_i || (ZERO_REG_HARDWIRED && src_reg_i == '0)) sel_o = SEL_W'(SEL_REGFILE);
  end
endmodule

// File: rtl/cpu_fw_scoreboard.sv
// cpu_fw_scoreboard: operand bypass selection plus latency scoreboard stalling decode.
module cpu_fw_scoreboard
  import cpu_fw_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_FW_STAGES = FW_STAGES,
  parameter int REG_W = 5,
  parameter int LAT_W = LAT_BITS,
  parameter bit ZERO_REG_HARDWIRED = 1'b1,
  parameter int STALL_CNT_W = 16,
  localparam int SEL_W = $clog2(NUM_FW_STAGES + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           issue_valid,
  input  logic                           issue_we,
  input  logic [REG_W-1:0]               issue_rd,
  input  logic [LAT_W-1:0]               issue_lat,
  input  logic [NUM_SRC*REG_W-1:0]       src_reg,
  input  logic [NUM_SRC-1:0]             src_used,
  input  logic [NUM_FW_STAGES*REG_W-1:0] stage_rd,
  input  logic [NUM_FW_STAGES-1:0]       stage_we,
  input  logic                           flush,
  output logic                           issue_accept,
  output logic [NUM_SRC*SEL_W-1:0]       bypass_sel,
  output logic                           stall,
  output logic [STALL_CNT_W-1:0]         stall_cycles
);
  localparam int NREG = 2 ** REG_W;
  logic [LAT_W-1:0] pend_q [NREG];
  logic [LAT_W-1:0] pend_d [NREG];
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC*SEL_W-1:0] sel;
  logic [NUM_SRC-1:0] hit;
  logic load;
  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      cpu_fw_select #(
        .NUM_FW_STAGES(NUM_FW_STAGES), .REG_W(REG_W), .SEL_W(SEL_W),
        .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
      ) u_sel (
        .src_reg_i(src_reg[i*REG_W +: REG_W]), .src_used_i(src_used[i]),
        .stage_rd_i(stage_rd), .stage_we_i(stage_we), .sel_o(sel[i*SEL_W +: SEL_W])
      );
      assign hit[i] = src_used[i] && pend_q[src_reg[i*REG_W +: REG_W]] != '0 &&
                      !(ZERO_REG_HARDWIRED && src_reg[i*REG_W +: REG_W] == '0);
    end
  endgenerate
  assign stall = |hit;
  assign issue_accept = reset && issue_valid && !stall;
  assign bypass_sel = reset ? sel : '0;
  assign stall_cycles = cnt_q;
  assign load = issue_accept && issue_we;
  // Flush wins over a same-cycle issue; an issue wins over the decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++)
      pend_d[r] = flush ? '0 : (load && issue_rd == REG_W'(r)) ? issue_lat :
                  pend_q[r] - LAT_W'(pend_q[r] != '0);
    cnt_d = cnt_q + STALL_CNT_W'(stall && !(&cnt_q));
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
      cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cpu_fw_scoreboard.sv
// tb_cpu_fw_scoreboard: randomized and directed scoreboard bench against a ready-time model.
module tb_cpu_fw_scoreboard;
  localparam int SCW = 6;
  logic clock = 1'b0, reset = 1'b0;
  logic issue_valid = 0, issue_we = 0, flush = 0;
  logic [4:0] issue_rd = '0;
  logic [1:0] issue_lat = '0, src_used = '0, stage_we = '0;
  logic [9:0] src_reg = '0, stage_rd = '0;
  logic issue_accept, stall;
  logic [3:0] bypass_sel;
  logic [SCW-1:0] stall_cycles;

  cpu_fw_scoreboard #(.STALL_CNT_W(SCW)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_reg(src_reg), .src_used(src_used),
    .stage_rd(stage_rd), .stage_we(stage_we), .flush(flush), .issue_accept(issue_accept),
    .bypass_sel(bypass_sel), .stall(stall), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct { int sel0; int sel1; int stl; int acc; int cnt; } exp_t;
  exp_t exp_q[$];
  int tests = 0, failed = 0;
  int cyc = 0;
  int busy_until[32];
  int cnt_m = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    foreach (busy_until[r]) busy_until[r] = -1;
    cnt_m = 0;
  endtask

  function automatic int ref_sel(input int r, input bit used, input int rd0, input int rd1, input logic [1:0] we);
    if (!used || r == 0) return 0;
    if (we[0] && rd0 == r) return 1;
    if (we[1] && rd1 == r) return 2;
    return 0;
  endfunction

  // Drive one cycle of inputs, predict the outputs, then advance the model past the edge.
  task automatic cycle(input bit iv, input bit we, input int rd, input int lat,
                       input int s0, input int s1, input logic [1:0] used,
                       input int r0, input int r1, input logic [1:0] swe, input bit fl);
    exp_t e;
    issue_valid = iv; issue_we = we; issue_rd = 5'(rd); issue_lat = 2'(lat);
    src_reg = {5'(s1), 5'(s0)}; src_used = used;
    stage_rd = {5'(r1), 5'(r0)}; stage_we = swe; flush = fl;
    e.sel0 = ref_sel(s0, used[0], r0, r1, swe);
    e.sel1 = ref_sel(s1, used[1], r0, r1, swe);
    e.stl = ((used[0] && s0 != 0 && cyc <= busy_until[s0]) ||
             (used[1] && s1 != 0 && cyc <= busy_until[s1])) ? 1 : 0;
    e.acc = (iv && e.stl == 0) ? 1 : 0;
    e.cnt = cnt_m;
    exp_q.push_back(e);
    if (fl) foreach (busy_until[r]) busy_until[r] = -1;
    else if (e.acc == 1 && we) busy_until[rd] = cyc + lat;
    if (e.stl == 1 && cnt_m < 2 ** SCW - 1) cnt_m++;
    @(posedge clock); #1;
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("bypass_sel0", int'(bypass_sel[1:0]), e.sel0);
        chk("bypass_sel1", int'(bypass_sel[3:2]), e.sel1);
        chk("stall", int'(stall), e.stl);
        chk("issue_accept", int'(issue_accept), e.acc);
        chk("stall_cycles", int'(stall_cycles), e.cnt);
      end
    end
  end

  initial begin : stim
    model_reset();
    src_reg = {5'd1, 5'd1}; src_used = 2'b11; stage_rd = {5'd1, 5'd1}; stage_we = 2'b11;
    issue_valid = 1;
    #1;
    chk("reset_bypass", int'(bypass_sel), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_accept", int'(issue_accept), 0);
    chk("reset_cnt", int'(stall_cycles), 0);
    #11 reset = 1'b1;
    @(posedge clock); #1;
    cycle(0, 0, 0, 0, 3, 4, 2'b11, 3, 4, 2'b11, 0);
    cycle(0, 0, 0, 0, 7, 1, 2'b01, 7, 7, 2'b11, 0);
    cycle(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 2'b11, 0);
    cycle(0, 0, 0, 0, 3, 4, 2'b10, 3, 4, 2'b11, 0);
    cycle(1, 1, 5, 2, 1, 2, 2'b00, 0, 0, 2'b00, 0);
    repeat (3) cycle(1, 1, 10, 0, 5, 1, 2'b01, 5, 0, 2'b01, 0);
    chk("cnt_after_lat2", int'(stall_cycles), 2);
    cycle(1, 1, 9, 3, 1, 2, 2'b00, 0, 0, 2'b00, 0);
    cycle(0, 0, 0, 0, 9, 1, 2'b01, 0, 0, 2'b00, 1);
    cycle(0, 0, 0, 0, 9, 1, 2'b01, 0, 0, 2'b00, 0);
    cycle(1, 1, 12, 3, 1, 2, 2'b00, 0, 0, 2'b00, 1);
    cycle(0, 0, 0, 0, 12, 1, 2'b01, 0, 0, 2'b00, 0);
    cycle(1, 1, 6, 3, 1, 2, 2'b00, 0, 0, 2'b00, 0);
    cycle(1, 1, 6, 1, 6, 2, 2'b00, 0, 0, 2'b00, 0);
    repeat (2) cycle(0, 0, 0, 0, 6, 1, 2'b01, 6, 0, 2'b01, 0);
    cycle(1, 1, 8, 3, 1, 2, 2'b00, 0, 0, 2'b00, 0);
    cycle(0, 0, 0, 0, 8, 1, 2'b01, 0, 0, 2'b00, 0);
    // Asynchronous reset pulse between edges while r8 is still pending.
    src_reg = {5'd1, 5'd8}; src_used = 2'b01; stage_rd = {5'd8, 5'd8}; stage_we = 2'b11;
    issue_valid = 1; issue_we = 0; flush = 0;
    #1 chk("pre_reset_stall", int'(stall), 1);
    reset = 1'b0;
    #1;
    chk("async_stall", int'(stall), 0);
    chk("async_cnt", int'(stall_cycles), 0);
    chk("async_bypass", int'(bypass_sel), 0);
    chk("async_accept", int'(issue_accept), 0);
    #1 reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    cyc++;
    cycle(0, 0, 0, 0, 8, 1, 2'b01, 0, 0, 2'b00, 0);
    for (int n = 0; n < (2 ** SCW + 5) / 3 + 2; n++) begin
      cycle(1, 1, 11, 3, 1, 2, 2'b00, 0, 0, 2'b00, 0);
      repeat (3) cycle(1, 0, 0, 0, 11, 1, 2'b01, 11, 0, 2'b01, 0);
    end
    chk("cnt_saturated", int'(stall_cycles), 2 ** SCW - 1);
    for (int n = 0; n < 1500; n++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
            $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
            $urandom_range(0, 19) == 0);
    @(negedge clock); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
